// File: rtl/imul_sched_pkg.sv
// rtl/imul_sched_pkg.sv - shared defaults, widths and shadow-entry type for imul_sched
package imul_sched_pkg;
  localparam int NPORT_DEF = 3;
  localparam int LAT_DEF   = 4;
  localparam int TAGW_DEF  = 9;
  localparam int PORTW_DEF = $clog2(NPORT_DEF);
  localparam int OPW       = 13;
  localparam int OPNDW     = 65;

  typedef struct packed {
    logic                 valid;
    logic [PORTW_DEF-1:0] port;
    logic [TAGW_DEF-1:0]  tag;
  } shadow_t;
endpackage

// File: rtl/imul_sched_arb.sv
// rtl/imul_sched_arb.sv - one-hot requester arbiter
// IMUL_SCHED_RR_EN selects round-robin; otherwise fixed priority, lowest index wins.
module imul_sched_arb
  import imul_sched_pkg::*;
#(
  parameter int NPORT = NPORT_DEF
) (
`ifdef IMUL_SCHED_RR_EN
  input  logic             clk,
  input  logic             rst,
`endif
  input  logic [NPORT-1:0] i_req,
  input  logic             i_en,
  output logic [NPORT-1:0] o_gnt
);

`ifdef IMUL_SCHED_RR_EN
  localparam int PW = (NPORT > 1) ? $clog2(NPORT) : 1;

  logic [PW-1:0] r_ptr;
  logic [PW-1:0] w_nxt;
  logic          w_found;
  int            w_idx;

  // Search starts at r_ptr; the pointer moves to one past the winner.
  always_comb begin
    o_gnt   = '0;
    w_found = 1'b0;
    w_nxt   = r_ptr;
    w_idx   = 0;
    for (int i = 0; i < NPORT; i++) begin
      w_idx = int'(r_ptr) + i;
      if (w_idx >= NPORT) w_idx = w_idx - NPORT;
      if (i_en && !w_found && i_req[w_idx]) begin
        o_gnt[w_idx] = 1'b1;
        w_found      = 1'b1;
        w_nxt        = (w_idx + 1 == NPORT) ? '0 : PW'(w_idx + 1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst)
      r_ptr <= '0;
    else if (w_found)
      r_ptr <= w_nxt;
  end
`else
  logic w_found;

  always_comb begin
    o_gnt   = '0;
    w_found = 1'b0;
    for (int i = 0; i < NPORT; i++) begin
      if (i_en && !w_found && i_req[i]) begin
        o_gnt[i] = 1'b1;
        w_found  = 1'b1;
      end
    end
  end
`endif

endmodule

// File: rtl/imul_sched.sv
// rtl/imul_sched.sv - issue scheduler sharing one imul among NPORT requesters
// IMUL_SCHED_RR_EN enables round-robin arbitration (default: fixed priority).
module imul_sched
  import imul_sched_pkg::*;
#(
  parameter int NPORT = NPORT_DEF,
  parameter int LAT   = LAT_DEF,
  parameter int TAGW  = TAGW_DEF
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     stall,
  input  logic                     flush,
  input  logic [NPORT-1:0]         req_vld,
  input  logic [NPORT*OPW-1:0]     req_op,
  input  logic [NPORT*OPNDW-1:0]   req_R,
  input  logic [NPORT*OPNDW-1:0]   req_C,
  input  logic [NPORT*TAGW-1:0]    req_tag,
  output logic [NPORT-1:0]         req_gnt,
  output logic                     mul_clkEn,
  output logic                     mul_en,
  output logic [OPW-1:0]           mul_op,
  output logic [OPNDW-1:0]         mul_R,
  output logic [OPNDW-1:0]         mul_C,
  output logic                     res_vld,
  output logic [$clog2(NPORT)-1:0] res_port,
  output logic [TAGW-1:0]          res_tag
);

  localparam int PW = $clog2(NPORT);

  logic              w_en;
  logic [NPORT-1:0]  w_gnt;
  logic [PW-1:0]     w_port;
  logic [TAGW-1:0]   w_tag;
  shadow_t           w_entry;
  shadow_t           r_pipe [LAT];

  assign w_en = ~stall & ~flush & ~rst;

  imul_sched_arb #(.NPORT(NPORT)) u_arb (
`ifdef IMUL_SCHED_RR_EN
    .clk   (clk),
    .rst   (rst),
`endif
    .i_req (req_vld),
    .i_en  (w_en),
    .o_gnt (w_gnt)
  );

  // AND-OR mux: all-zero operands whenever nothing is granted.
  always_comb begin
    mul_op = '0;
    mul_R  = '0;
    mul_C  = '0;
    w_tag  = '0;
    w_port = '0;
    for (int i = 0; i < NPORT; i++) begin
      if (w_gnt[i]) begin
        mul_op = mul_op | req_op[i*OPW +: OPW];
        mul_R  = mul_R  | req_R[i*OPNDW +: OPNDW];
        mul_C  = mul_C  | req_C[i*OPNDW +: OPNDW];
        w_tag  = w_tag  | req_tag[i*TAGW +: TAGW];
        w_port = w_port | PW'(i);
      end
    end
  end

  assign req_gnt   = w_gnt;
  assign mul_en    = |w_gnt;
  assign mul_clkEn = ~stall;

  always_comb begin
    w_entry       = '0;
    w_entry.valid = mul_en;
    w_entry.port  = PORTW_DEF'(w_port);
    w_entry.tag   = TAGW_DEF'(w_tag);
  end

  // Shadow tracks the imul pipeline; it only moves when the multiplier is clocked.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < LAT; i++) r_pipe[i] <= '0;
    end else if (flush) begin
      for (int i = 0; i < LAT; i++) r_pipe[i].valid <= 1'b0;
    end else if (!stall) begin
      r_pipe[0] <= w_entry;
      for (int i = 1; i < LAT; i++) r_pipe[i] <= r_pipe[i-1];
    end
  end

  assign res_vld  = r_pipe[LAT-1].valid & ~flush & ~rst;
  assign res_port = rst ? '0 : PW'(r_pipe[LAT-1].port);
  assign res_tag  = rst ? '0 : TAGW'(r_pipe[LAT-1].tag);

endmodule
